// File: rtl/dmem_core_port.sv
// dmem_core_port
// Core-side initiator for one port of the shared dual-port data RAM.
// It accepts single or burst read/write requests from a load/store unit and
// sequences the RAM's level-driven RD/WR/address/data pins. Read words come
// back as a valid-strobed stream. A burst whose last word would reach or pass
// MEM_DEPTH is rejected before any RAM access.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (accepted only in IDLE)
//   req_we/addr/len       burst direction, start word, length minus one
//   wdata/valid/ready     write-word handshake (taken only in WR_WAIT)
//   rdata/rdata_valid     read word, valid for one cycle, no backpressure
//   done/err              one-cycle burst-end pulse, err when rejected
//   mem_addr/din/wr/rd    RAM ADDBUS/DATAIN/WR/RD
//   mem_dout              RAM DATAOUT
//
// All outputs are registered. Each is loaded from the next-state decode, so
// its value always matches the state it is presented in.
module dmem_core_port #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MEM_DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_len,
  input  logic [DW-1:0] wdata,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_wr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ON   = 3'd1,
    S_RD_OFF  = 3'd2,
    S_WR_WAIT = 3'd3,
    S_WR_ON   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state_r, state_s;
  logic [AW-1:0] cur_addr_r, cur_addr_s;
  logic [7:0]    remain_r, remain_s;
  logic          err_pending_r, err_pending_s;

  logic [AW:0]   end_addr_s;
  logic          over_s;

  logic          req_ready_r, wdata_ready_r, rdata_valid_r, done_r, err_r;
  logic          mem_wr_r, mem_rd_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_din_r, rdata_r;

  // Last word address of the requested burst, one bit wider so it cannot wrap.
  assign end_addr_s = {1'b0, req_addr} + {{(AW-7){1'b0}}, req_len};
  assign over_s     = (end_addr_s >= (AW+1)'(MEM_DEPTH));

  // Next-state and burst-bookkeeping decode.
  always_comb begin
    state_s       = state_r;
    cur_addr_s    = cur_addr_r;
    remain_s      = remain_r;
    err_pending_s = err_pending_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          cur_addr_s = req_addr;
          remain_s   = req_len;
          if (over_s) begin
            err_pending_s = 1'b1;
            state_s       = S_DONE;
          end else if (req_we) begin
            state_s = S_WR_WAIT;
          end else begin
            state_s = S_RD_ON;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD_ON: begin
        state_s = S_RD_OFF;
      end
      S_RD_OFF: begin
        // Dropping RD here gives the RAM one rising RD edge per word.
        if (remain_r == 8'd0) begin
          state_s = S_DONE;
        end else begin
          remain_s   = remain_r - 8'd1;
          cur_addr_s = cur_addr_r + {{(AW-1){1'b0}}, 1'b1};
          state_s    = S_RD_ON;
        end
      end
      S_WR_WAIT: begin
        if (wdata_valid) begin
          state_s = S_WR_ON;
        end else begin
          state_s = S_WR_WAIT;
        end
      end
      S_WR_ON: begin
        if (remain_r == 8'd0) begin
          state_s = S_DONE;
        end else begin
          remain_s   = remain_r - 8'd1;
          cur_addr_s = cur_addr_r + {{(AW-1){1'b0}}, 1'b1};
          state_s    = S_WR_WAIT;
        end
      end
      S_DONE: begin
        err_pending_s = 1'b0;
        state_s       = S_IDLE;
      end
      default: begin
        err_pending_s = 1'b0;
        state_s       = S_IDLE;
      end
    endcase
  end

  // State, burst bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      cur_addr_r    <= {AW{1'b0}};
      remain_r      <= 8'd0;
      err_pending_r <= 1'b0;
      req_ready_r   <= 1'b1;
      wdata_ready_r <= 1'b0;
      rdata_valid_r <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      mem_wr_r      <= 1'b0;
      mem_rd_r      <= 1'b0;
      mem_addr_r    <= {AW{1'b0}};
      mem_din_r     <= {DW{1'b0}};
      rdata_r       <= {DW{1'b0}};
    end else begin
      state_r       <= state_s;
      cur_addr_r    <= cur_addr_s;
      remain_r      <= remain_s;
      err_pending_r <= err_pending_s;
      req_ready_r   <= (state_s == S_IDLE);
      wdata_ready_r <= (state_s == S_WR_WAIT);
      rdata_valid_r <= (state_s == S_RD_OFF);
      done_r        <= (state_s == S_DONE);
      err_r         <= (state_s == S_DONE) && err_pending_s;
      mem_wr_r      <= (state_s == S_WR_ON);
      mem_rd_r      <= (state_s == S_RD_ON);
      // Address only moves when a RAM access starts; it holds otherwise.
      if ((state_s == S_RD_ON) || (state_s == S_WR_ON)) begin
        mem_addr_r <= cur_addr_s;
      end
      // The RAM drives DATAOUT while RD is high; capture at the closing edge.
      if (state_r == S_RD_ON) begin
        rdata_r <= mem_dout;
      end
      if ((state_r == S_WR_WAIT) && wdata_valid) begin
        mem_din_r <= wdata;
      end
    end
  end

  assign req_ready   = req_ready_r;
  assign wdata_ready = wdata_ready_r;
  assign rdata_valid = rdata_valid_r;
  assign rdata       = rdata_r;
  assign done        = done_r;
  assign err         = err_r;
  assign mem_wr      = mem_wr_r;
  assign mem_rd      = mem_rd_r;
  assign mem_addr    = mem_addr_r;
  assign mem_din     = mem_din_r;

endmodule

// File: doc/dmem_core_port.md
# dmem_core_port

Core-side initiator for one port of the shared dual-port data RAM. It accepts single or burst read/write requests from a core's load/store unit and sequences the RAM's level-driven `RD`/`WR`/address/data pins. It returns read data as a valid-strobed stream and flags out-of-range bursts. One instance sits between each core and its RAM port (port 1 or port 2).

## Interface
- `AW`, 16, address width of core request and RAM address bus
- `DW`, 16, data width
- `MEM_DEPTH`, 1024, number of RAM words; bursts that reach or pass this bound are rejected
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  core request strobe
- `req_ready`  out  1  controller can accept a request
- `req_we`  in  1  1 = write burst, 0 = read burst
- `req_addr`  in  AW  start word address
- `req_len`  in  8  burst length minus one (0 = 1 word, 255 = 256 words)
- `wdata`  in  DW  write word from core
- `wdata_valid`  in  1  `wdata` present
- `wdata_ready`  out  1  controller takes `wdata` this cycle
- `rdata`  out  DW  captured read word
- `rdata_valid`  out  1  `rdata` valid for this cycle only; no backpressure
- `done`  out  1  one-cycle pulse at burst end
- `err`  out  1  one-cycle pulse with `done` when the burst was rejected
- `mem_addr`  out  AW  to RAM `ADDBUS`
- `mem_din`  out  DW  to RAM `DATAIN`
- `mem_wr`  out  1  to RAM `WR`
- `mem_rd`  out  1  to RAM `RD`
- `mem_dout`  in  DW  from RAM `DATAOUT`

## Operation
- States: IDLE, RD_ON, RD_OFF, WR_WAIT, WR_ON, DONE.
- IDLE: `req_ready`=1. On `req_valid`, latch `req_we`, `req_addr` into `cur_addr`, and `req_len` into `remain` (8-bit).
  - Bound check: compute `req_addr + req_len` in AW+1 bits. If the result is ≥ `MEM_DEPTH`, go to DONE with `err_pending` set and make no RAM access.
  - Otherwise go to RD_ON if `req_we`=0, or WR_WAIT if `req_we`=1.
- RD_ON: `mem_rd`=1 and `mem_addr`=`cur_addr`. The RAM's read is triggered by the `RD` rising edge. At the end of this cycle, register `mem_dout` into `rdata`. Next state is RD_OFF.
- RD_OFF: `mem_rd`=0, which returns the RAM output to Z. `rdata_valid`=1.
  - If `remain`=0, go to DONE.
  - Otherwise decrement `remain`, increment `cur_addr`, and go to RD_ON.
  - `RD` therefore toggles once per word, as the RAM requires.
- WR_WAIT: `wdata_ready`=1 and `mem_wr`=0. On `wdata_valid`, register `wdata` into `mem_din` and go to WR_ON. The controller stalls indefinitely while `wdata_valid`=0.
- WR_ON: `mem_wr`=1, with `mem_addr`=`cur_addr` and `mem_din` stable all cycle. The RAM commits on the closing edge.
  - If `remain`=0, go to DONE.
  - Otherwise decrement `remain`, increment `cur_addr`, and go to WR_WAIT.
- DONE: `done`=1, `err`=`err_pending`, `req_ready`=0. Clear `err_pending` and go to IDLE.
- `mem_rd` and `mem_wr` are never high in the same cycle.
- `mem_addr` holds its last value when idle.
- Request inputs are ignored outside IDLE. `wdata_valid` is ignored outside WR_WAIT.

## Timing
- Reset, asynchronous on `rst_n`=0:
  - State goes to IDLE.
  - `mem_rd`, `mem_wr`, `rdata_valid`, `done`, `err`, `wdata_ready` go to 0.
  - `mem_addr`, `mem_din`, `rdata`, `remain`, `cur_addr` go to 0.
  - `req_ready`=1 after release.
- Reset mid-burst aborts at once. `mem_wr` drops asynchronously, so a word is committed only if its WR_ON closing edge occurred before reset.
- Read: request accepted at edge 0 → `mem_rd` high in cycle 1 → `rdata_valid` in cycle 2. Each further word adds 2 cycles. `done` comes in the cycle after the last RD_OFF. An N-word read is accepted to `done` in 2N+1 cycles.
- Write, with `wdata_valid` held high: 2 cycles per word (WR_WAIT, WR_ON), and `done` follows the last WR_ON. An N-word write takes 2N+1 cycles minimum.
- Rejected burst: accept → DONE next cycle, with `done`=`err`=1 for one cycle.
- Back-to-back: `req_ready` returns 1 in the cycle after DONE.
- The address never wraps: the bound check rejects the whole burst before the first access.

## Test plan
- Preload mem[5]=0x1234. Issue a read with addr=5, len=0 → `mem_rd` high exactly 1 cycle, `rdata_valid` with `rdata`=0x1234 two cycles after accept, `done` one cycle later, `err`=0.
- Write addr=10, len=2, data 0xA0/0xA1/0xA2 with `wdata_valid` always high → mem[10..12]=0xA0..0xA2, three single-cycle `mem_wr` pulses, `done` 7 cycles after accept.
- Same write, but drop `wdata_valid` for 3 cycles before the second word → `mem_wr` stays 0 during the stall, final memory contents unchanged from the previous case, `done` 3 cycles later.
- Read addr=1020, len=3 (MEM_DEPTH=1024), which reaches 1023 → accepted with 4 `rdata_valid` pulses. Then addr=1021, len=3 → `done`=`err`=1 next cycle, `mem_rd` never asserted.
- Assert `rst_n`=0 during the WR_WAIT of word 2 of a 4-word write → all outputs 0 immediately, only word 1 written, `req_ready`=1 after release.
- Read burst len=1 immediately followed by a write request → second request accepted in the first IDLE cycle, `mem_rd` and `mem_wr` never overlap.
